// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates ICache, load/store buffer and prefetcher requests onto the
//   byte-serial memory controller's flag/commit interface. One request is
//   latched and presented at a time; the controller's completion is routed
//   back to the owner as a one-cycle commit pulse with its data.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global ready, low freezes the block (commits forced 0)
//   roll                pipeline rollback pulse
//   IC_flag/IC_addr     ICache 4-byte read request
//   IC_commit/IC_data   ICache completion pulse and word
//   LSB_flag/type/addr/len/data   LSB request (type 1 = store, len 1/2/4)
//   LSB_commit/LSB_val  LSB completion pulse and load data
//   PF_flag/PF_addr     prefetch 4-byte read request
//   PF_commit/PF_data   prefetch completion pulse and word
//   MC_flag/type/addr/len/data    latched request to the memory controller
//   MC_commit/MC_val    controller completion
//
// Configuration
//   MEMARB_PREFETCH_EN  when defined the PF port takes part in arbitration;
//                       otherwise PF inputs are ignored and PF outputs are 0.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        roll,
  input  logic        IC_flag,
  input  logic [31:0] IC_addr,
  output logic        IC_commit,
  output logic [31:0] IC_data,
  input  logic        LSB_flag,
  input  logic        LSB_type,
  input  logic [31:0] LSB_addr,
  input  logic [2:0]  LSB_len,
  input  logic [31:0] LSB_data,
  output logic        LSB_commit,
  output logic [31:0] LSB_val,
  input  logic        PF_flag,
  input  logic [31:0] PF_addr,
  output logic        PF_commit,
  output logic [31:0] PF_data,
  output logic        MC_flag,
  output logic        MC_type,
  output logic [31:0] MC_addr,
  output logic [2:0]  MC_len,
  output logic [31:0] MC_data,
  input  logic        MC_commit,
  input  logic [31:0] MC_val
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_IC, OWN_LSB, OWN_PF} owner_t;

  state_t      state;
  owner_t      owner;
  logic [2:0]  starve_cnt;
  logic        pend;       // completion captured while rdy was low
  logic [31:0] pend_val;

  logic        gnt_ic, gnt_lsb, gnt_pf, gnt_any;
  logic        keep_store;
  logic [31:0] done_val;

  always_comb begin
    gnt_ic  = 1'b0;
    gnt_lsb = 1'b0;
    gnt_pf  = 1'b0;
    if (IC_flag && starve_cnt == LIMIT) gnt_ic = 1'b1;
    else if (LSB_flag)                  gnt_lsb = 1'b1;
    else if (IC_flag)                   gnt_ic = 1'b1;
`ifdef MEMARB_PREFETCH_EN
    else if (PF_flag)                   gnt_pf = 1'b1;
`endif
    gnt_any = gnt_ic | gnt_lsb | gnt_pf;
  end

  // A store already handed to the controller must run to completion.
  assign keep_store = (state == S_BUSY) && (owner == OWN_LSB) && MC_type;
  assign done_val   = pend ? pend_val : MC_val;

`ifndef MEMARB_PREFETCH_EN
  logic pf_unused;
  assign pf_unused = ^{PF_flag, PF_addr};
  assign PF_commit = 1'b0;
  assign PF_data   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IC;
      starve_cnt <= '0;
      pend       <= 1'b0;
      pend_val   <= '0;
      MC_flag    <= 1'b0;
      MC_type    <= 1'b0;
      MC_addr    <= '0;
      MC_len     <= '0;
      MC_data    <= '0;
      IC_commit  <= 1'b0;
      IC_data    <= '0;
      LSB_commit <= 1'b0;
      LSB_val    <= '0;
`ifdef MEMARB_PREFETCH_EN
      PF_commit  <= 1'b0;
      PF_data    <= '0;
`endif
    end else if (!rdy) begin
      IC_commit  <= 1'b0;
      LSB_commit <= 1'b0;
`ifdef MEMARB_PREFETCH_EN
      PF_commit  <= 1'b0;
`endif
      // Controller completions are pulses; remember one seen while frozen.
      if (state == S_BUSY && MC_commit && !pend) begin
        pend     <= 1'b1;
        pend_val <= MC_val;
      end
    end else begin
      IC_commit  <= 1'b0;
      LSB_commit <= 1'b0;
`ifdef MEMARB_PREFETCH_EN
      PF_commit  <= 1'b0;
`endif
      if (roll && !keep_store) begin
        state   <= S_IDLE;
        MC_flag <= 1'b0;
        pend    <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (gnt_lsb) begin
              owner   <= OWN_LSB;
              MC_type <= LSB_type;
              MC_addr <= LSB_addr;
              MC_len  <= LSB_len;
              MC_data <= LSB_type ? LSB_data : '0;
            end else if (gnt_ic) begin
              owner   <= OWN_IC;
              MC_type <= 1'b0;
              MC_addr <= IC_addr;
              MC_len  <= 3'd4;
              MC_data <= '0;
            end
`ifdef MEMARB_PREFETCH_EN
            else if (gnt_pf) begin
              owner   <= OWN_PF;
              MC_type <= 1'b0;
              MC_addr <= PF_addr;
              MC_len  <= 3'd4;
              MC_data <= '0;
            end
`endif
            if (gnt_any) begin
              MC_flag <= 1'b1;
              state   <= S_BUSY;
              if (gnt_lsb && IC_flag)
                starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 3'd1;
              else
                starve_cnt <= '0;
            end
          end
          S_BUSY: begin
            if (MC_commit || pend) begin
              pend    <= 1'b0;
              MC_flag <= 1'b0;
              state   <= S_GAP;
              unique case (owner)
                OWN_IC: begin
                  IC_commit <= 1'b1;
                  IC_data   <= done_val;
                end
                OWN_LSB: begin
                  LSB_commit <= 1'b1;
                  LSB_val    <= done_val;
                end
`ifdef MEMARB_PREFETCH_EN
                OWN_PF: begin
                  PF_commit <= 1'b1;
                  PF_data   <= done_val;
                end
`endif
                default: ;
              endcase
            end
          end
          S_GAP:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, with a memory-controller model, a grant-priority model
// and per-requester scoreboard queues checked by a monitor.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, roll;
  logic        IC_flag, IC_commit;
  logic [31:0] IC_addr, IC_data;
  logic        LSB_flag, LSB_type, LSB_commit;
  logic [31:0] LSB_addr, LSB_data, LSB_val;
  logic [2:0]  LSB_len;
  logic        PF_flag, PF_commit;
  logic [31:0] PF_addr, PF_data;
  logic        MC_flag, MC_type, MC_commit;
  logic [31:0] MC_addr, MC_data, MC_val;
  logic [2:0]  MC_len;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
    .IC_flag(IC_flag), .IC_addr(IC_addr), .IC_commit(IC_commit), .IC_data(IC_data),
    .LSB_flag(LSB_flag), .LSB_type(LSB_type), .LSB_addr(LSB_addr), .LSB_len(LSB_len),
    .LSB_data(LSB_data), .LSB_commit(LSB_commit), .LSB_val(LSB_val),
    .PF_flag(PF_flag), .PF_addr(PF_addr), .PF_commit(PF_commit), .PF_data(PF_data),
    .MC_flag(MC_flag), .MC_type(MC_type), .MC_addr(MC_addr), .MC_len(MC_len),
    .MC_data(MC_data), .MC_commit(MC_commit), .MC_val(MC_val)
  );

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        ic_q[$], lsb_q[$], pf_q[$];
  int unsigned n_cmp = 0, n_bad = 0;
  logic [31:0] log_code = '0;  // 2 bits per commit: 1 IC, 2 LSB, 3 PF
  int          mc_lat_fix = -1;
  bit          rnd_done = 1'b0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Controller memory contents
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h00C5_8593;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int pick_lat();
    if (mc_lat_fix >= 0) return mc_lat_fix;
    return int'($urandom_range(0, 3));
  endfunction

  // Memory controller model: answers a raised MC_flag after a latency,
  // abandons it if the flag drops, and waits for the flag to fall after
  // each completion.
  initial begin : mc_model
    int lat;
    bit wdrop;
    lat = 0;
    wdrop = 1'b0;
    MC_commit = 1'b0;
    MC_val = '0;
    forever begin
      @(posedge clk); #1;
      MC_commit = 1'b0;
      if (wdrop) begin
        if (!MC_flag) begin
          wdrop = 1'b0;
          lat = pick_lat();
        end
      end else if (MC_flag) begin
        if (lat <= 0) begin
          MC_commit = 1'b1;
          MC_val = memf(MC_addr);
          wdrop = 1'b1;
        end else lat--;
      end else lat = pick_lat();
    end
  end

  // Monitor: grant priority/field model and commit scoreboard.
  initial begin : monitor
    bit          p_ok;
    logic        p_rst, p_rdy, p_roll, p_ic, p_lsb, p_pf, p_mc, p_lsbt;
    logic [31:0] p_ica, p_lsba, p_lsbd, p_pfa;
    logic [2:0]  p_lsbl;
    int          starve, w, ncm;
    exp_t        e;
    p_ok = 1'b0;
    starve = 0;
    forever begin
      @(negedge clk);
      if (p_ok) begin
        if (!p_mc && MC_flag) begin
          w = -1;
          if (!p_rst && p_rdy && !p_roll) begin
            if (p_ic && starve == int'(LIMIT)) w = 0;
            else if (p_lsb) w = 1;
            else if (p_ic) w = 0;
`ifdef MEMARB_PREFETCH_EN
            else if (p_pf) w = 2;
`endif
          end
          check("grant_allowed", {95'd0, w >= 0}, 96'd1);
          if (w == 0)
            check("grant_ic_fields", {MC_type, MC_len, MC_addr, MC_data}, {1'b0, 3'd4, p_ica, 32'h0});
          else if (w == 1)
            check("grant_lsb_fields", {MC_type, MC_len, MC_addr, MC_data},
                  {p_lsbt, p_lsbl, p_lsba, p_lsbt ? p_lsbd : 32'h0});
          else if (w == 2)
            check("grant_pf_fields", {MC_type, MC_len, MC_addr, MC_data}, {1'b0, 3'd4, p_pfa, 32'h0});
          if (w == 1 && p_ic) starve = (starve + 1 > int'(LIMIT)) ? int'(LIMIT) : starve + 1;
          else starve = 0;
        end
        if (p_rst) starve = 0;
        if (p_rst || !p_rdy)
          check("commit_frozen", {93'd0, IC_commit, LSB_commit, PF_commit}, 96'd0);
      end
      ncm = $countones({IC_commit, LSB_commit, PF_commit});
      if (ncm != 0) begin
        check("commit_onehot", ncm, 1);
        check("mc_flag_in_gap", MC_flag, 0);
        if (IC_commit === 1'b1) begin
          log_code = {log_code[29:0], 2'd1};
          check("ic_commit_expected", ic_q.size() != 0, 1);
          if (ic_q.size() != 0) begin
            e = ic_q.pop_front();
            check("ic_data", IC_data, e.data);
          end
        end
        if (LSB_commit === 1'b1) begin
          log_code = {log_code[29:0], 2'd2};
          check("lsb_commit_expected", lsb_q.size() != 0, 1);
          if (lsb_q.size() != 0) begin
            e = lsb_q.pop_front();
            if (e.chk) check("lsb_val", LSB_val, e.data);
          end
        end
        if (PF_commit === 1'b1) begin
          log_code = {log_code[29:0], 2'd3};
          check("pf_commit_expected", pf_q.size() != 0, 1);
          if (pf_q.size() != 0) begin
            e = pf_q.pop_front();
            check("pf_data", PF_data, e.data);
          end
        end
      end
      p_rst = rst; p_rdy = rdy; p_roll = roll; p_mc = MC_flag;
      p_ic = IC_flag; p_ica = IC_addr;
      p_lsb = LSB_flag; p_lsbt = LSB_type; p_lsba = LSB_addr; p_lsbl = LSB_len; p_lsbd = LSB_data;
      p_pf = PF_flag; p_pfa = PF_addr;
      p_ok = 1'b1;
    end
  end

  // Requesters: raise a request, push its expected completion, hold until
  // the commit is seen, then drop the flag (or keep it for a follow-on).
  task automatic ic_req(input logic [31:0] a);
    bit got;
    @(posedge clk); #1;
    IC_addr = a;
    IC_flag = 1'b1;
    ic_q.push_back('{1'b1, memf(a)});
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (IC_commit) begin got = 1'b1; break; end
    end
    check("ic_completes", got, 1);
    IC_flag = 1'b0;
  endtask

  task automatic lsb_req(input logic [31:0] a, input logic t, input logic [2:0] l,
                         input logic [31:0] d, input bit keep);
    bit got;
    @(posedge clk); #1;
    LSB_addr = a; LSB_type = t; LSB_len = l; LSB_data = d;
    LSB_flag = 1'b1;
    lsb_q.push_back('{!t, memf(a)});
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (LSB_commit) begin got = 1'b1; break; end
    end
    check("lsb_completes", got, 1);
    if (!keep || !got) LSB_flag = 1'b0;
  endtask

  task automatic pf_req(input logic [31:0] a);
    bit got;
    @(posedge clk); #1;
    PF_addr = a;
    PF_flag = 1'b1;
    pf_q.push_back('{1'b1, memf(a)});
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (PF_commit) begin got = 1'b1; break; end
    end
    check("pf_completes", got, 1);
    PF_flag = 1'b0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit got;
    rst = 1'b1; rdy = 1'b1; roll = 1'b0;
    IC_flag = 1'b0; IC_addr = '0;
    LSB_flag = 1'b0; LSB_type = 1'b0; LSB_addr = '0; LSB_len = '0; LSB_data = '0;
    PF_flag = 1'b0; PF_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_mc", {MC_flag, MC_type, MC_len, MC_addr, MC_data}, 96'd0);
    check("reset_commit", {IC_commit, LSB_commit, PF_commit}, 96'd0);
    check("reset_data", {IC_data, LSB_val, PF_data}, 96'd0);
    rst = 1'b0;

    // Single ICache fetch
    log_code = '0;
    ic_req(32'h0000_1000);
    check("ic_fetch_data", IC_data, 32'h00C5_8593);
    @(posedge clk); #1;
    check("ic_fetch_order", log_code, 32'h1);

    // Simultaneous requests
    log_code = '0;
    fork
      ic_req(32'h0000_1100);
      lsb_req(32'h0000_2000, 1'b0, 3'd2, 32'h0, 1'b0);
`ifdef MEMARB_PREFETCH_EN
      pf_req(32'h0000_3000);
`endif
    join
    @(posedge clk); #1;
`ifdef MEMARB_PREFETCH_EN
    check("priority_order", log_code, 32'h27);
`else
    check("priority_order", log_code, 32'h9);
`endif

    // ICache starvation guard: 4 LSB grants, then IC, then remaining LSB
    log_code = '0;
    fork
      ic_req(32'h0000_1200);
      for (int i = 0; i < 6; i++)
        lsb_req(32'h0000_2100 + 32'(i * 4), 1'b0, 3'd4, 32'h0, i < 5);
    join
    @(posedge clk); #1;
    check("starve_order", log_code, 32'h2A9A);

    // Rollback during an in-flight store: store completes untouched
    mc_lat_fix = 6;
    log_code = '0;
    fork
      lsb_req(32'h0003_0000, 1'b1, 3'd4, 32'hDEAD_BEEF, 1'b0);
      begin
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #1;
          if (MC_flag) begin got = 1'b1; break; end
        end
        check("store_granted", got, 1);
        roll = 1'b1;
        @(posedge clk); #1;
        roll = 1'b0;
        check("store_roll_mc", {MC_flag, MC_type, MC_len, MC_addr, MC_data},
              {1'b1, 1'b1, 3'd4, 32'h0003_0000, 32'hDEAD_BEEF});
      end
    join
    @(posedge clk); #1;
    check("store_roll_commit", log_code, 32'h2);

    // Rollback during an ICache read: request abandoned, no commit
    log_code = '0;
    IC_addr = 32'h0000_4000;
    IC_flag = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (MC_flag) begin got = 1'b1; break; end
    end
    check("ic_roll_granted", got, 1);
    roll = 1'b1;
    IC_flag = 1'b0;
    @(posedge clk); #1;
    roll = 1'b0;
    check("ic_roll_drop", MC_flag, 0);
    repeat (8) @(posedge clk);
    #1;
    check("ic_roll_no_commit", log_code, 32'h0);

    // rdy low in the controller-commit cycle
    mc_lat_fix = 2;
    log_code = '0;
    fork
      ic_req(32'h0000_5000);
      begin
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #2;
          if (MC_commit) begin got = 1'b1; break; end
        end
        check("rdy_commit_seen", got, 1);
        rdy = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("rdy_low_no_commit", IC_commit, 0);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        check("rdy_release_commit", {IC_commit, IC_data}, {1'b1, memf(32'h0000_5000)});
        @(posedge clk); #1;
        check("rdy_release_once", IC_commit, 0);
      end
    join
    mc_lat_fix = -1;
    @(posedge clk); #1;
    check("rdy_commit_count", log_code, 32'h1);

`ifndef MEMARB_PREFETCH_EN
    // Prefetch port disabled
    PF_addr = 32'h0000_6000;
    PF_flag = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("pf_disabled", {MC_flag, PF_commit, PF_data}, 96'd0);
    end
    PF_flag = 1'b0;
`endif

    // Randomized traffic with random rdy stalls
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            ic_req($urandom() & 32'hFFFF_FFFC);
          end
          for (int i = 0; i < 40; i++) begin
            bit          kp;
            logic [2:0]  ln;
            kp = (i < 39) && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
              0:       ln = 3'd1;
              1:       ln = 3'd2;
              default: ln = 3'd4;
            endcase
            lsb_req($urandom(), 1'($urandom_range(0, 1)), ln, $urandom(), kp);
            if (!kp) repeat ($urandom_range(0, 4)) @(posedge clk);
          end
`ifdef MEMARB_PREFETCH_EN
          for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            pf_req($urandom() & 32'hFFFF_FFFC);
          end
`endif
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          rdy = ($urandom_range(0, 7) != 0);
        end
        rdy = 1'b1;
      end
    join

    repeat (4) @(posedge clk);
    #1;
    check("queues_drained", ic_q.size() + lsb_q.size() + pf_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
